// File: rtl/lsu_pipelined.sv
// Generic FIFO: registered push, combinational head read; occupancy exported for flow control.
// Zero-latency read of the head entry; caller must not push when full or pop when empty.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           push_vld,
   input  logic [WIDTH-1:0]               push_dat,
   input  logic                           pop_vld,
   output logic [WIDTH-1:0]               pop_dat,
   output logic [$clog2(DEPTH+1)-1:0]     cnt
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_vld) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
         if (pop_vld)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
         case ({push_vld, pop_vld})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_vld) mem[wr_ptr] <= push_dat;
   end

   assign pop_dat = mem[rd_ptr];
endmodule

// Pipelined load/store unit: EA, byte enables, lane-replicated store data, in-order outstanding bus accesses.
// Responses/errors are registered (1 cycle after bus rvalid / acceptance); requests stall while MAX_OUTSTANDING are in flight.
module lsu_pipelined #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    lsu_req_valid_i,
   output logic                    lsu_req_ready_o,
   input  logic                    lsu_we_i,
   input  logic [1:0]              lsu_type_i,
   input  logic                    lsu_sign_ext_i,
   input  logic [ADDR_WIDTH-1:0]   lsu_operand_a_i,
   input  logic [ADDR_WIDTH-1:0]   lsu_operand_b_i,
   input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
   output logic                    lsu_rvalid_o,
   output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
   output logic                    lsu_err_o,
   output logic                    data_req_o,
   input  logic                    data_gnt_i,
   input  logic                    data_rvalid_i,
   output logic [ADDR_WIDTH-1:0]   data_addr_o,
   output logic                    data_we_o,
   output logic [DATA_WIDTH/8-1:0] data_be_o,
   output logic [DATA_WIDTH-1:0]   data_wdata_o,
   input  logic [DATA_WIDTH-1:0]   data_rdata_i
);
   localparam int BEW = DATA_WIDTH / 8;
   localparam int OFF = $clog2(BEW);
   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

   typedef struct packed {
      logic           we;
      logic [1:0]     typ;
      logic           sign;
      logic [OFF-1:0] off;
   } meta_t;

   logic [ADDR_WIDTH-1:0] ea;
   logic [OFF-1:0]        off;
   logic                  illegal;
   logic                  issue_ok;
   logic                  push;
   logic                  pop;
   logic [CW-1:0]         cnt;
   meta_t                 push_meta;
   meta_t                 head;
   logic [BEW-1:0]        be;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] mask;
   logic                  msb;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  rvalid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   assign ea  = lsu_operand_a_i + lsu_operand_b_i;
   assign off = ea[OFF-1:0];

   always_comb begin
      illegal = 1'b0;
      case (lsu_type_i)
         2'b01:   illegal = ea[0];
         2'b10:   illegal = |ea[1:0];
         2'b11:   illegal = (DATA_WIDTH == 32) ? 1'b1 : |ea[2:0];
         default: illegal = 1'b0;
      endcase
   end

   // Gate on the pre-pop count so a same-cycle response never lets a full FIFO overflow.
   assign issue_ok        = (cnt < CW'(MAX_OUTSTANDING));
   assign data_req_o      = lsu_req_valid_i && !illegal && issue_ok;
   assign lsu_req_ready_o = lsu_req_valid_i && (illegal || (issue_ok && data_gnt_i));
   assign push            = data_req_o && data_gnt_i;
   assign pop             = data_rvalid_i && (cnt != '0);

   always_comb begin
      be    = '1;
      wdata = lsu_wdata_i;
      case (lsu_type_i)
         2'b00: begin
            be    = BEW'(1) << off;
            wdata = {(DATA_WIDTH/8){lsu_wdata_i[7:0]}};
         end
         2'b01: begin
            be    = BEW'(3) << off;
            wdata = {(DATA_WIDTH/16){lsu_wdata_i[15:0]}};
         end
         2'b10: begin
            be    = BEW'(4'hF) << off;
            wdata = {(DATA_WIDTH/32){lsu_wdata_i[31:0]}};
         end
         default: begin
            be    = '1;
            wdata = lsu_wdata_i;
         end
      endcase
   end

   assign data_addr_o  = data_req_o ? (ea & ~ADDR_WIDTH'(BEW-1)) : '0;
   assign data_we_o    = data_req_o & lsu_we_i;
   assign data_be_o    = data_req_o ? be : '0;
   assign data_wdata_o = data_req_o ? wdata : '0;

   assign push_meta = '{we: lsu_we_i, typ: lsu_type_i, sign: lsu_sign_ext_i, off: off};

   fifo #(
      .WIDTH ($bits(meta_t)),
      .DEPTH (MAX_OUTSTANDING)
   ) u_meta_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .push_vld (push),
      .push_dat (push_meta),
      .pop_vld  (pop),
      .pop_dat  (head),
      .cnt      (cnt)
   );

   // Extension by masking keeps every access size legal for both bus widths.
   always_comb begin
      shifted = data_rdata_i >> {head.off, 3'b000};
      mask    = '1;
      msb     = shifted[DATA_WIDTH-1];
      case (head.typ)
         2'b00: begin
            mask = DATA_WIDTH'(8'hFF);
            msb  = shifted[7];
         end
         2'b01: begin
            mask = DATA_WIDTH'(16'hFFFF);
            msb  = shifted[15];
         end
         2'b10: begin
            mask = DATA_WIDTH'(32'hFFFF_FFFF);
            msb  = shifted[31];
         end
         default: begin
            mask = '1;
            msb  = shifted[DATA_WIDTH-1];
         end
      endcase
      load_data = (shifted & mask) | ((head.sign && msb) ? ~mask : '0);
      if (head.we) load_data = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= pop;
         rdata_q  <= pop ? load_data : '0;
         err_q    <= lsu_req_valid_i && illegal;
      end
   end

   assign lsu_rvalid_o = rvalid_q;
   assign lsu_rdata_o  = rdata_q;
   assign lsu_err_o    = err_q;
endmodule

// File: tb/tb_lsu_pipelined.sv
// Self-checking bench for lsu_pipelined: vector table for single accesses plus hand-built pipelining/reset sequences.
module tb_lsu_pipelined;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        lsu_req_valid_i = 1'b0;
   logic        lsu_req_ready_o;
   logic        lsu_we_i = 1'b0;
   logic [1:0]  lsu_type_i = 2'b00;
   logic        lsu_sign_ext_i = 1'b0;
   logic [31:0] lsu_operand_a_i = '0;
   logic [31:0] lsu_operand_b_i = '0;
   logic [31:0] lsu_wdata_i = '0;
   logic        lsu_rvalid_o;
   logic [31:0] lsu_rdata_o;
   logic        lsu_err_o;
   logic        data_req_o;
   logic        data_gnt_i = 1'b0;
   logic        data_rvalid_i = 1'b0;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic [31:0] data_rdata_i = '0;

   lsu_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .lsu_req_valid_i (lsu_req_valid_i),
      .lsu_req_ready_o (lsu_req_ready_o),
      .lsu_we_i        (lsu_we_i),
      .lsu_type_i      (lsu_type_i),
      .lsu_sign_ext_i  (lsu_sign_ext_i),
      .lsu_operand_a_i (lsu_operand_a_i),
      .lsu_operand_b_i (lsu_operand_b_i),
      .lsu_wdata_i     (lsu_wdata_i),
      .lsu_rvalid_o    (lsu_rvalid_o),
      .lsu_rdata_o     (lsu_rdata_o),
      .lsu_err_o       (lsu_err_o),
      .data_req_o      (data_req_o),
      .data_gnt_i      (data_gnt_i),
      .data_rvalid_i   (data_rvalid_i),
      .data_addr_o     (data_addr_o),
      .data_we_o       (data_we_o),
      .data_be_o       (data_be_o),
      .data_wdata_o    (data_wdata_o),
      .data_rdata_i    (data_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        we;
      logic [1:0]  typ;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] wdata;
      logic [31:0] bus;
      logic        req;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t        vecs[14];
   logic [31:0] rsp_q[$];
   int          err_pend = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Response monitor: pops the scoreboard on every output pulse.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (lsu_rvalid_o) begin
            if (rsp_q.size() == 0) check("unexpected_rvalid", 1, 0);
            else check("rsp_rdata", lsu_rdata_o, rsp_q.pop_front());
         end
         if (lsu_err_o) begin
            check("unexpected_err", (err_pend > 0) ? 1 : 0, 1);
            if (err_pend > 0) err_pend--;
         end
      end
   end

   task automatic apply_vec(input vec_t v);
      lsu_req_valid_i = 1'b1;
      lsu_we_i        = v.we;
      lsu_type_i      = v.typ;
      lsu_sign_ext_i  = v.sgn;
      lsu_operand_a_i = v.a;
      lsu_operand_b_i = v.b;
      lsu_wdata_i     = v.wdata;
      data_gnt_i      = 1'b1;
      @(negedge clk_i);
      check("data_req", data_req_o, v.req);
      check("req_ready", lsu_req_ready_o, 1);
      check("data_we", data_we_o, v.req ? v.we : 1'b0);
      check("data_addr", data_addr_o, v.addr);
      check("data_be", data_be_o, v.be);
      check("data_wdata", data_wdata_o, v.wd);
      if (v.err) err_pend++;
      if (v.req) rsp_q.push_back(v.rdata);
      tick();
      lsu_req_valid_i = 1'b0;
      data_gnt_i      = 1'b0;
      if (v.req) begin
         data_rvalid_i = 1'b1;
         data_rdata_i  = v.bus;
      end
      @(negedge clk_i);
      check("err_pulse", lsu_err_o, v.err);
      check("early_rvalid", lsu_rvalid_o, 0);
      tick();
      data_rvalid_i = 1'b0;
      tick();
      tick();
      check("drain", rsp_q.size() + err_pend, 0);
   endtask

   initial begin
      //           we  typ   sg  a             b             wdata         bus           req addr          be    wd            err rdata
      vecs[0]  = '{0, 2'd2, 0, 32'h100,      32'h4,        32'h0,        32'hDEADBEEF, 1, 32'h104,      4'hF, 32'h0,        0, 32'hDEADBEEF};
      vecs[1]  = '{0, 2'd0, 1, 32'h100,      32'h3,        32'h0,        32'h80112233, 1, 32'h100,      4'h8, 32'h0,        0, 32'hFFFFFF80};
      vecs[2]  = '{0, 2'd0, 0, 32'h100,      32'h3,        32'h0,        32'h80112233, 1, 32'h100,      4'h8, 32'h0,        0, 32'h00000080};
      vecs[3]  = '{1, 2'd1, 0, 32'h200,      32'h2,        32'h1234ABCD, 32'h55555555, 1, 32'h200,      4'hC, 32'hABCDABCD, 0, 32'h0};
      vecs[4]  = '{0, 2'd1, 1, 32'h104,      32'h2,        32'h0,        32'h9ABC1234, 1, 32'h104,      4'hC, 32'h0,        0, 32'hFFFF9ABC};
      vecs[5]  = '{0, 2'd1, 0, 32'h100,      32'hFFFFFFFE, 32'h0,        32'h7FFF0000, 1, 32'hFC,       4'hC, 32'h0,        0, 32'h00007FFF};
      vecs[6]  = '{0, 2'd0, 1, 32'h300,      32'h1,        32'h0,        32'h00007F00, 1, 32'h300,      4'h2, 32'h0,        0, 32'h0000007F};
      vecs[7]  = '{1, 2'd0, 0, 32'h1,        32'h2,        32'hFFFFFFA5, 32'h0,        1, 32'h0,        4'h8, 32'hA5A5A5A5, 0, 32'h0};
      vecs[8]  = '{1, 2'd2, 0, 32'h10,       32'h0,        32'hCAFEF00D, 32'h0,        1, 32'h10,       4'hF, 32'hCAFEF00D, 0, 32'h0};
      vecs[9]  = '{0, 2'd2, 0, 32'h100,      32'h2,        32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1, 32'h0};
      vecs[10] = '{0, 2'd1, 0, 32'h105,      32'h0,        32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1, 32'h0};
      vecs[11] = '{0, 2'd3, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1, 32'h0};
      vecs[12] = '{1, 2'd2, 0, 32'h200,      32'h1,        32'h12345678, 32'h0,        0, 32'h0,        4'h0, 32'h0,        1, 32'h0};
      vecs[13] = '{0, 2'd0, 0, 32'h0,        32'h0,        32'h0,        32'h123456F0, 1, 32'h0,        4'h1, 32'h0,        0, 32'h000000F0};

      // Reset state
      #3;
      check("rst_rvalid", lsu_rvalid_o, 0);
      check("rst_err", lsu_err_o, 0);
      check("rst_rdata", lsu_rdata_o, 0);
      check("rst_req", data_req_o, 0);
      check("rst_ready", lsu_req_ready_o, 0);
      check("rst_be", data_be_o, 0);
      #9 rst_ni = 1'b1;
      tick();

      foreach (vecs[i]) apply_vec(vecs[i]);

      // Three back-to-back loads with MAX_OUTSTANDING=2 and delayed responses
      lsu_req_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'd2; lsu_sign_ext_i = 1'b0;
      lsu_operand_a_i = 32'h400; lsu_operand_b_i = 32'h0; data_gnt_i = 1'b1;
      @(negedge clk_i);
      check("b2b_req1", lsu_req_ready_o, 1);
      rsp_q.push_back(32'h11111111);
      tick();
      lsu_operand_a_i = 32'h404;
      @(negedge clk_i);
      check("b2b_req2", lsu_req_ready_o, 1);
      rsp_q.push_back(32'h22222222);
      tick();
      lsu_operand_a_i = 32'h408;
      @(negedge clk_i);
      check("full_data_req", data_req_o, 0);
      check("full_ready", lsu_req_ready_o, 0);
      tick();
      data_rvalid_i = 1'b1; data_rdata_i = 32'h11111111;
      @(negedge clk_i);
      check("full_pop_ready", lsu_req_ready_o, 0);
      tick();
      data_rdata_i = 32'h22222222;
      @(negedge clk_i);
      check("issue_with_pop_ready", lsu_req_ready_o, 1);
      check("issue_with_pop_addr", data_addr_o, 32'h408);
      rsp_q.push_back(32'h33333333);
      tick();
      lsu_req_valid_i = 1'b0; data_gnt_i = 1'b0;
      data_rdata_i = 32'h33333333;
      tick();
      data_rvalid_i = 1'b0;
      tick();
      tick();
      check("b2b_drain", rsp_q.size(), 0);

      // Stray bus response with nothing outstanding
      data_rvalid_i = 1'b1; data_rdata_i = 32'hBADBAD00;
      tick();
      data_rvalid_i = 1'b0;
      @(negedge clk_i);
      check("stray_rvalid", lsu_rvalid_o, 0);
      tick();

      // Misaligned word load: no bus request, error next cycle
      lsu_req_valid_i = 1'b1; lsu_type_i = 2'd2; lsu_operand_a_i = 32'h102; lsu_operand_b_i = 32'h0;
      @(negedge clk_i);
      check("mis_req", data_req_o, 0);
      check("mis_ready", lsu_req_ready_o, 1);
      err_pend++;
      tick();
      lsu_req_valid_i = 1'b0;
      @(negedge clk_i);
      check("mis_err", lsu_err_o, 1);
      check("mis_rvalid", lsu_rvalid_o, 0);
      tick();

      // Reset with two loads outstanding
      lsu_req_valid_i = 1'b1; lsu_type_i = 2'd2; lsu_operand_a_i = 32'h600; data_gnt_i = 1'b1;
      tick();
      lsu_operand_a_i = 32'h604;
      tick();
      lsu_req_valid_i = 1'b0; data_gnt_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      check("midrst_rvalid", lsu_rvalid_o, 0);
      check("midrst_err", lsu_err_o, 0);
      check("midrst_rdata", lsu_rdata_o, 0);
      check("midrst_req", data_req_o, 0);
      tick();
      rst_ni = 1'b1;
      data_rvalid_i = 1'b1; data_rdata_i = 32'hBADBAD11;
      tick();
      data_rvalid_i = 1'b0;
      @(negedge clk_i);
      check("post_rst_stray", lsu_rvalid_o, 0);
      tick();
      // Count must be zero: two issues accepted back to back
      lsu_req_valid_i = 1'b1; lsu_operand_a_i = 32'h700; data_gnt_i = 1'b1;
      @(negedge clk_i);
      check("post_rst_ready1", lsu_req_ready_o, 1);
      rsp_q.push_back(32'h600DF00D);
      tick();
      lsu_operand_a_i = 32'h704;
      @(negedge clk_i);
      check("post_rst_ready2", lsu_req_ready_o, 1);
      rsp_q.push_back(32'h0BADCAFE);
      tick();
      lsu_req_valid_i = 1'b0; data_gnt_i = 1'b0;
      data_rvalid_i = 1'b1; data_rdata_i = 32'h600DF00D;
      tick();
      data_rdata_i = 32'h0BADCAFE;
      tick();
      data_rvalid_i = 1'b0;
      tick();
      tick();
      check("final_drain", rsp_q.size() + err_pend, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
